// File: rtl/div_seq_unit_pkg.sv
// Shared types for the sequential restoring divider.
// Holds the FSM state type and the default operand width.
package div_seq_unit_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_seq_unit_if.sv
// Request/result handshake bundle for div_seq_unit.
// master drives requests and consumes results; slave is the divider.
interface div_seq_unit_if
    import div_seq_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             err;
    logic             busy;

    modport master (
        output in_valid, num, den, out_ready,
        input  in_ready, out_valid, quo, rem, err, busy
    );

    modport slave (
        input  in_valid, num, den, out_ready,
        output in_ready, out_valid, quo, rem, err, busy
    );
endinterface

// File: rtl/div_seq_step.sv
// One restoring-division step: shift in a dividend bit,
// compare against the divisor and subtract when it fits.
module div_seq_step
    import div_seq_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_den,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_den;

    assign w_shift = {i_rem, i_bit};
    assign w_den   = (WIDTH+2)'(i_den);
    assign o_qbit  = (w_shift >= w_den);
    assign o_rem   = o_qbit ? (WIDTH+1)'(w_shift - w_den)
                            : w_shift[WIDTH:0];
endmodule

// File: rtl/div_seq_unit.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// DIV_SEQ_ZERO_TRAP_EN: divide-by-zero skips BUSY and flags err.
module div_seq_unit
    import div_seq_unit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    div_seq_unit_if.slave ifc
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH:0]   r_prem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_den;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH:0]   w_next_rem;
    logic             w_qbit;
    logic             w_accept;
    logic             w_last;
    logic             w_zero;

    assign w_accept = ifc.in_valid & (r_state == ST_IDLE);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

`ifdef DIV_SEQ_ZERO_TRAP_EN
    logic r_err;
    assign w_zero  = (ifc.den == '0);
    assign ifc.err = r_err;
`else
    assign w_zero  = 1'b0;
    assign ifc.err = 1'b0;
`endif

    div_seq_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_prem),
        .i_bit  (r_dvd[WIDTH-1]),
        .i_den  (r_den),
        .o_rem  (w_next_rem),
        .o_qbit (w_qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept)
                         w_state_nx = w_zero ? ST_DONE : ST_BUSY;
            ST_BUSY: if (w_last)
                         w_state_nx = ST_DONE;
            ST_DONE: if (ifc.out_ready)
                         w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Freed dividend bits are refilled with quotient bits as they form
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prem <= '0;
            r_dvd  <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
`ifdef DIV_SEQ_ZERO_TRAP_EN
            r_err  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_prem <= '0;
            r_dvd  <= ifc.num;
            r_den  <= ifc.den;
            r_cnt  <= '0;
`ifdef DIV_SEQ_ZERO_TRAP_EN
            if (w_zero) begin
                r_quo <= '1;
                r_rem <= ifc.num;
                r_err <= 1'b1;
            end
`endif
        end else if (r_state == ST_BUSY) begin
            r_prem <= w_next_rem;
            r_dvd  <= {r_dvd[WIDTH-2:0], w_qbit};
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_cnt <= '0;
                r_quo <= {r_dvd[WIDTH-2:0], w_qbit};
                r_rem <= w_next_rem[WIDTH-1:0];
`ifdef DIV_SEQ_ZERO_TRAP_EN
                r_err <= 1'b0;
`endif
            end
        end
    end

    assign ifc.in_ready  = (r_state == ST_IDLE);
    assign ifc.out_valid = (r_state == ST_DONE);
    assign ifc.busy      = (r_state == ST_BUSY);
    assign ifc.quo       = r_quo;
    assign ifc.rem       = r_rem;
endmodule

// File: doc/div_seq_unit.md
DIV_SEQ_UNIT -- requirements
Module: div_seq_unit

Interface
REQ-001 Parameter WIDTH, default 8: operand, quotient and remainder width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  request carries valid num/den this cycle.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 num  input  WIDTH  unsigned dividend.
REQ-007 den  input  WIDTH  unsigned divisor.
REQ-008 out_valid  output  1  quo/rem/err hold a completed result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 quo  output  WIDTH  registered quotient.
REQ-011 rem  output  WIDTH  registered remainder.
REQ-012 err  output  1  divide-by-zero flag; see Configuration.
REQ-013 busy  output  1  high while state is BUSY.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, DONE; encoding is free.
REQ-015 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready at a rising edge.
REQ-016 On accept: latch num/den; clear partial remainder (WIDTH+1 bits) and step counter; go to BUSY.
REQ-017 BUSY: one restoring step per clock, MSB-first: shift remainder left, shift in next dividend bit, compare against den, subtract if >=, write quotient bit 1 else 0.
REQ-018 After exactly WIDTH BUSY steps, go to DONE; quo/rem/out_valid SHALL be valid WIDTH clocks after the accept edge.
REQ-019 DONE: out_valid=1; quo/rem/err stable until out_ready=1.
REQ-020 DONE with out_ready=1: go to IDLE next edge; out_valid drops; no request accepted in that same cycle.
REQ-021 in_valid outside IDLE SHALL be ignored; num/den changes during BUSY have no effect.
REQ-022 Without the macro, den=0 SHALL run the normal WIDTH steps, giving quo=all ones, rem=num, err=0.
REQ-023 quo/rem SHALL keep the last result after DONE exits; new values appear only on the next DONE entry.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE; quo=0, rem=0, err=0, out_valid=0, busy=0, counter=0.
REQ-025 rst overrides every other input, including mid-BUSY and in DONE; the in-flight result is discarded.
REQ-026 in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro DIV_SEQ_ZERO_TRAP_EN.
REQ-028 Defined: accept with den=0 SHALL go straight to DONE at the accept edge, with quo=all ones, rem=num, err=1; out_valid is high 1 clock after accept.
REQ-029 Defined: err SHALL be 0 for every den!=0 result.
REQ-030 Undefined: err is tied 0 and REQ-022 applies.

Structure
REQ-031 The shared package holds the FSM state type/constants and the default WIDTH constant.
REQ-032 One combinational sub-module, div_seq_step, SHALL perform a single shift/compare/subtract step: in remainder, dividend bit, den; out next remainder, quotient bit.
REQ-033 The counter SHALL be clog2(WIDTH)+1 bits; no combinational path from in_valid to in_ready or from out_ready to out_valid.

Verification
REQ-034 num=100, den=7, out_ready=1 -> out_valid exactly 8 clocks after accept; quo=14, rem=2, err=0.
REQ-035 Back-to-back 255/1 then 5/9 -> quo=255, rem=0, then quo=0, rem=5; in_ready low throughout BUSY/DONE.
REQ-036 num=200, den=13, out_ready held 0 for 3 clocks in DONE -> quo=15, rem=5 held stable with out_valid=1; IDLE the clock after out_ready=1.
REQ-037 num=42, den=0 -> with macro: err=1, quo=255, rem=42, 1 clock after accept; without macro: same quo/rem after 8 clocks, err=0.
REQ-038 rst pulsed at BUSY step 4 of 100/7 -> next cycle IDLE, quo=0, rem=0, out_valid=0, in_ready=1; a fresh 9/3 then gives quo=3, rem=0.
